// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, controller state encoding,
// the latched request bundle and the legal-opcode check.
package proc_pkg;

  localparam logic [6:0] OP_NONE  = 7'd0;
  localparam logic [6:0] OP_STORE = 7'd1;
  localparam logic [6:0] OP_ADD   = 7'd2;
  localparam logic [6:0] OP_SUB   = 7'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_DM_WR,
    S_DM_RD,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } req_t;

  function automatic logic op_is_legal(input logic [6:0] op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/datapath_controller.sv
// Sequencer for store/add/sub over register file, ALU and data memory.
// CTRL_STORE_READBACK_EN adds a data-memory readback cycle after a store.
module datapath_controller
  import proc_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] op_code,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] rf_addr_a,
  output logic [4:0] rf_addr_b,
  output logic       rf_write_en,
  output logic [4:0] rf_write_addr,
  output logic       alu_sub,
  output logic       dm_write_enable,
  output logic       dm_read,
  output logic [4:0] dm_addr
);

  if (WORDSIZE < 1) begin : g_bad_wordsize
    $error("datapath_controller: WORDSIZE must be positive");
  end

  state_e state_q, state_d;
  req_t   req_q, req_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic rf_we_q, rf_we_d;
  logic alu_sub_q, alu_sub_d;
  logic dm_we_q, dm_we_d;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          req_d.op  = op_code;
          req_d.rs1 = rs1;
          req_d.rs2 = rs2;
          req_d.rd  = rd;
          if (op_is_legal(op_code) && op_code != OP_NONE)
            state_d = S_READ;
          else
            state_d = S_DONE;
        end
      end
      S_READ:
        state_d = (req_q.op == OP_STORE) ? S_DM_WR : S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_DONE;
`ifdef CTRL_STORE_READBACK_EN
      S_DM_WR: state_d = S_DM_RD;
`else
      S_DM_WR: state_d = S_DONE;
`endif
      S_DM_RD: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    busy_d    = state_d != S_IDLE;
    done_d    = state_d == S_DONE;
    err_d     = done_d && !op_is_legal(req_d.op);
    rf_we_d   = state_d == S_WB;
    dm_we_d   = state_d == S_DM_WR;
    alu_sub_d = (req_d.op == OP_SUB) &&
                (state_d inside {S_READ, S_EXEC, S_WB});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rf_we_q   <= 1'b0;
      alu_sub_q <= 1'b0;
      dm_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rf_we_q   <= rf_we_d;
      alu_sub_q <= alu_sub_d;
      dm_we_q   <= dm_we_d;
    end
  end

`ifdef CTRL_STORE_READBACK_EN
  logic dm_read_q, dm_read_d;

  always_comb dm_read_d = state_d == S_DM_RD;

  always_ff @(posedge clk) begin
    if (rst) dm_read_q <= 1'b0;
    else     dm_read_q <= dm_read_d;
  end

  assign dm_read = dm_read_q;
`else
  assign dm_read = 1'b0;
`endif

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rf_write_en     = rf_we_q;
  assign alu_sub         = alu_sub_q;
  assign dm_write_enable = dm_we_q;
  assign rf_addr_a       = req_q.rs1;
  assign rf_addr_b       = req_q.rs2;
  assign rf_write_addr   = req_q.rd;
  assign dm_addr         = req_q.rd;

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: directed scenarios plus random traffic
// against a cycle-count reference model of each operation's schedule.
module tb_datapath_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] op_code = '0;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic [4:0] rd = '0;
  logic       busy, done, err;
  logic [4:0] rf_addr_a, rf_addr_b, rf_write_addr, dm_addr;
  logic       rf_write_en, alu_sub, dm_write_enable, dm_read;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index within the current operation (0 = idle)
  int         k = 0;
  logic [6:0] m_op = '0;
  logic [4:0] m_a = '0, m_b = '0, m_d = '0;

`ifdef CTRL_STORE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  always #5 clk = ~clk;

  datapath_controller #(.WORDSIZE(64)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .busy(busy), .done(done), .err(err),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
    .alu_sub(alu_sub), .dm_write_enable(dm_write_enable),
    .dm_read(dm_read), .dm_addr(dm_addr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  function automatic int lat(input logic [6:0] op);
    if (op == 7'd1) return RB ? 4 : 3;
    if (op == 7'd2 || op == 7'd3) return 4;
    return 1;
  endfunction

  // {busy, done, err, rf_we, alu_sub, dm_we, dm_read}
  function automatic logic [6:0] exp_ctrl();
    logic addsub, st, last;
    if (k == 0) return '0;
    addsub = (m_op == 7'd2) || (m_op == 7'd3);
    st     = m_op == 7'd1;
    last   = k == lat(m_op);
    return {1'b1, last, last && (m_op > 7'd3),
            addsub && k == 3,
            (m_op == 7'd3) && k <= 3,
            st && k == 2,
            RB && st && k == 3};
  endfunction

  task automatic tick(input logic r, input logic s, input logic [6:0] op,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d);
    logic [6:0] got;
    rst = r; start = s; op_code = op; rs1 = a; rs2 = b; rd = d;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0; m_op = '0; m_a = '0; m_b = '0; m_d = '0;
    end else if (k == 0) begin
      if (s) begin
        m_op = op; m_a = a; m_b = b; m_d = d; k = 1;
      end
    end else if (k == lat(m_op)) begin
      k = 0;
    end else begin
      k++;
    end
    got = {busy, done, err, rf_write_en, alu_sub, dm_write_enable, dm_read};
    check("ctrl", 32'(got), 32'(exp_ctrl()));
    check("addr", {12'd0, rf_addr_a, rf_addr_b, rf_write_addr, dm_addr},
          {12'd0, m_a, m_b, m_d, m_d});
    check("excl", 32'($countones({rf_write_en, dm_write_enable, dm_read}) <= 1),
          32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, 1'b0, 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom));
  endtask

  initial begin
    tick(1'b1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick(1'b1, 1'b1, 7'd2, 5'd1, 5'd1, 5'd1);
    idle(2);
    // add, sub, store, illegal, none
    tick(1'b0, 1'b1, 7'd2, 5'd2, 5'd3, 5'd10);
    idle(5);
    tick(1'b0, 1'b1, 7'd3, 5'd4, 5'd5, 5'd14);
    idle(5);
    tick(1'b0, 1'b1, 7'd1, 5'd4, 5'd0, 5'd7);
    idle(5);
    tick(1'b0, 1'b1, 7'h7F, 5'd9, 5'd8, 5'd6);
    idle(3);
    tick(1'b0, 1'b1, 7'd0, 5'd1, 5'd2, 5'd3);
    idle(3);
    // start held with changing op during an add
    tick(1'b0, 1'b1, 7'd2, 5'd2, 5'd3, 5'd10);
    for (int i = 0; i < 6; i++)
      tick(1'b0, 1'b1, 7'(i % 4), 5'(i), 5'(i + 1), 5'(i + 20));
    idle(6);
    // reset in EXEC
    tick(1'b0, 1'b1, 7'd2, 5'd2, 5'd3, 5'd10);
    tick(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick(1'b1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [6:0] op;
      sel = $urandom_range(0, 9);
      op  = (sel < 8) ? 7'(sel % 4) : 7'($urandom);
      tick($urandom_range(0, 63) == 0, 1'($urandom), op,
           5'($urandom), 5'($urandom), 5'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
DATAPATH_CONTROLLER -- requirements
Module: datapath_controller

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, datapath word width (passed through to width-dependent outputs).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to execute one operation; sampled only in IDLE.
REQ-005 SHALL have port op_code  input  7  0=none, 1=store, 2=add, 3=sub; any other value is illegal.
REQ-006 SHALL have ports rs1, rs2, rd  input  5 each  register/memory indices.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port err  output  1  illegal op_code flag, valid while done=1.
REQ-010 SHALL have ports rf_addr_a, rf_addr_b  output  5 each  register file read addresses (latched rs1, rs2).
REQ-011 SHALL have ports rf_write_en (output, 1) and rf_write_addr (output, 5)  register file write enable and address (latched rd).
REQ-012 SHALL have port alu_sub  output  1  0=add, 1=subtract, to adder_subtractor.
REQ-013 SHALL have ports dm_write_enable, dm_read (output, 1 each) and dm_addr (output, 5)  data memory controls; dm_addr = latched rd.

Function
REQ-014 SHALL implement states IDLE, READ, EXEC, WB, DM_WR, DM_RD, DONE.
REQ-015 SHALL, in IDLE with start=1, latch op_code, rs1, rs2 and rd at that edge; the latched values stay stable until return to IDLE.
REQ-016 SHALL, after latching, go to READ for valid ops 1..3, and straight to DONE for op 0 or illegal ops.
REQ-017 SHALL go READ->EXEC for add/sub and READ->DM_WR for store.
REQ-018 SHALL go EXEC->WB->DONE for add/sub, with rf_write_en=1 only in WB.
REQ-019 SHALL hold alu_sub=1 from READ through WB for sub, and 0 otherwise.
REQ-020 SHALL assert dm_write_enable=1 only in DM_WR; store writes rf[rs1] to mem[rd].
REQ-021 SHALL go DONE->IDLE unconditionally, with done=1 for exactly that cycle.
REQ-022 SHALL have latency, counted from the accept edge to done high: add/sub 4 cycles; store 3 cycles (4 with readback); op 0 or illegal 1 cycle.
REQ-023 SHALL ignore start while busy=1; a new request is accepted no earlier than the first IDLE cycle after DONE.
REQ-024 SHALL, for an illegal op, set err=1 in DONE and produce no rf or dm side effect; err SHALL be 0 in all other cycles.
REQ-025 SHALL never assert more than one of rf_write_en, dm_write_enable, dm_read in the same cycle.

Reset
REQ-026 SHALL, with rst=1 at a posedge, enter IDLE, clear the latched fields to 0, and drive every output to 0 (including busy, done, err and all enables).
REQ-027 SHALL let rst abort any in-progress operation, so that no rf or dm write occurs in the cycle after rst is sampled.
REQ-028 SHALL give rst priority over start when both are high.

Configuration
REQ-029 SHALL, when CTRL_STORE_READBACK_EN is defined, insert DM_RD after DM_WR for store (dm_read=1 for one cycle).
REQ-030 SHALL, when CTRL_STORE_READBACK_EN is not defined, omit DM_RD entirely, keep dm_read tied to 0, and go DM_WR->DONE.

Structure
REQ-031 SHALL take op_code constants, the state encoding and the illegal-op check from a shared package proc_pkg, which processor and its testbenches also use.
REQ-032 SHALL contain no sub-module; instantiating register_file, data_memory and adder_subtractor remains processor's job.

Verification
REQ-033 SHALL cover add: rs1=2, rs2=3, rd=10, start pulse -> alu_sub=0, rf_write_en=1 with rf_write_addr=10 in cycle 3, done=1 in cycle 4, err=0.
REQ-034 SHALL cover sub: rs1=4, rs2=5, rd=14 -> alu_sub=1 in cycles 1-3, rf_write_en in cycle 3 only, done in cycle 4.
REQ-035 SHALL cover store: rs1=4, rd=7 -> dm_write_enable=1 with dm_addr=7 in cycle 2, rf_write_en never high, done in cycle 3 (cycle 4 with dm_read=1 in cycle 3 under CTRL_STORE_READBACK_EN).
REQ-036 SHALL cover illegal op: op_code=7'h7F -> done=1 and err=1 in cycle 1, no enables ever high.
REQ-037 SHALL cover busy handling: start held high with op changing during an add -> second op accepted only after IDLE, first result unaffected.
REQ-038 SHALL cover reset mid-op: rst=1 in EXEC -> next cycle IDLE, all outputs 0, no rf write follows.
